rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

Registered, parametrised round-robin arbitrating multiplexer for the RISC-V processor datapath. It selects one of CH requesting channels (each N bits wide) with rotating priority, and holds the winner in an output register under a valid/ready handshake. The pipelined core uses it wherever several producers share one consumer, e.g. instruction fetch and load/store sharing a single memory port. Selection is stateful and fair, unlike a plain select-driven multiplexer.

## Interface
- N, 32: data width per channel.
- CH, 4: number of request channels, ≥ 2.
- SW, $clog2(CH): width of the channel index (derived; not to be overridden).
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- req_valid  input  CH  bit i: channel i presents data.
- req_data  input  CH*N  channel i data in bits [i*N +: N].
- req_ready  output  CH  bit i: channel i's data is accepted this cycle (combinational, one-hot or zero).
- out_valid  output  1  output register holds a valid word.
- out_data  output  N  registered winning data.
- out_sel  output  SW  index of channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- State: output register {out_valid, out_data, out_sel}, and priority pointer ptr (SW bits) = channel index with highest priority next.
- Load enable: ld = !out_valid || out_ready.
- Grant: g = first i in cyclic order ptr, ptr+1, …, CH-1, 0, …, ptr-1 with req_valid[i]=1; if none, no grant.
- req_ready[g] = ld when a grant exists; all other bits 0. req_ready depends only on req_valid, ptr, out_valid, out_ready (no combinational loop through req_data).
- Transfer on channel g: req_valid[g] && req_ready[g]. Next edge: out_data ← req_data[g], out_sel ← g, out_valid ← 1, ptr ← (g+1) mod CH (wrap from CH-1 to 0; CH need not be a power of two).
- Drain only (out_valid && out_ready, no grant): out_valid ← 0; out_data/out_sel keep last values.
- Drain and grant in the same cycle: the output is replaced by the new word; out_valid stays 1. No bubble.
- Stall (out_valid && !out_ready): req_ready all 0; out_data, out_sel, ptr frozen. Output stable until accepted.
- No requests: ptr unchanged.
- Requesters may drop req_valid without a transfer. The block imposes no obligation on them.

## Timing
- Reset (rst=1 at edge): out_valid=0, out_data=0, out_sel=0, ptr=0. req_ready evaluates to 0 while rst=1. Reset overrides any concurrent transfer or drain. A held word is discarded.
- Latency: request accepted at edge t is visible on out_* after edge t (one cycle).
- Throughput: one word per cycle when out_ready is held at 1.
- Fairness: with all CH channels continuously valid and out_ready=1, grants cycle ptr, ptr+1, … so each channel wins exactly once per CH transfers. Worst-case wait is CH-1 transfers.
- First cycle after reset: channel 0 has highest priority.

## Test plan
- Reset then single request: N=32, CH=4. req_valid=0100, req_data[2]=0xDEADBEEF. Expect req_ready=0100 that cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2; ptr=3.
- Full contention rotation: req_valid=1111 held, out_ready=1 from reset. Expect out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_valid continuously 1 after the first cycle.
- Backpressure: out_valid=1, out_sel=1, out_ready=0 for 3 cycles while req_valid=1111. Expect req_ready=0000, out_data/out_sel unchanged. Raising out_ready gives req_ready=0100 and next out_sel=2.
- Wrap and skip: ptr=3, req_valid=0011. Expect grant to channel 0 (wrap past 3), then ptr=1, next grant channel 1.
- Simultaneous drain and load: out_valid=1, out_ready=1, req_valid=1000. Expect out_valid stays 1, out_sel=3 next cycle. With req_valid=0000 instead, expect out_valid=0 next cycle.
- Reset mid-operation: assert rst while out_valid=1, out_ready=0, req_valid=1111. Expect out_valid=0, out_data=0, out_sel=0 after the edge. First grant after release goes to channel 0.

Source files
------------

// File: rtl/rr_arb_mux.sv
// Round-robin arbitrating multiplexer with a registered output stage.
// Rotating priority picks one of CH requesters and holds the winner under valid/ready.
module rr_arb_mux #(
    parameter int N  = 32,
    parameter int CH = 4,
    parameter int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   req_valid,
    input  logic [CH*N-1:0] req_data,
    output logic [CH-1:0]   req_ready,
    output logic            out_valid,
    output logic [N-1:0]    out_data,
    output logic [SW-1:0]   out_sel,
    input  logic            out_ready
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt_idx;
    logic          gnt_found;
    logic          ld;
    logic          xfer;
    logic [SW-1:0] ptr_next;

    // Cyclic search starting at ptr; the first requester found wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < CH; k++) begin
            logic [SW-1:0] idx;
            idx = SW'((int'(ptr) + k) % CH);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    assign ld       = !out_valid || out_ready;
    assign xfer     = gnt_found && ld && !rst;
    assign ptr_next = (gnt_idx == SW'(CH - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready = CH'(1) << gnt_idx;
        end
    end

    // Output register stage: load on grant, otherwise drain when accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= req_data[int'(gnt_idx)*N +: N];
            out_sel   <= gnt_idx;
            ptr       <= ptr_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed table-driven bench for rr_arb_mux (N=32, CH=4), plus fairness and stall sequences.
module tb_rr_arb_mux;

    localparam int N  = 32;
    localparam int CH = 4;
    localparam int SW = 2;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_1111;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'h4444_3333;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   req_valid;
    logic [CH*N-1:0] req_data;
    logic [CH-1:0]   req_ready;
    logic            out_valid;
    logic [N-1:0]    out_data;
    logic [SW-1:0]   out_sel;
    logic            out_ready;

    rr_arb_mux #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic        ordy;
        logic [3:0]  rr;
        logic        ov;
        logic [1:0]  sel;
        logic [31:0] data;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [3:0] rv, input logic ordy);
        @(negedge clk);
        rst       = r;
        req_valid = rv;
        out_ready = ordy;
        #1;
    endtask

    int cnt[CH];

    initial begin
        // rst, req_valid, out_ready | req_ready, out_valid, out_sel, out_data (after edge)
        vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
        vecs[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
        vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, D2};
        vecs[3]  = '{1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
        vecs[4]  = '{1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
        vecs[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0};
        vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
        vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
        vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
        vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
        vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
        vecs[11] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
        vecs[12] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
        vecs[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
        vecs[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
        vecs[15] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
        vecs[16] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
        vecs[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, D3};
        vecs[18] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, D1};
        vecs[19] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0};
        vecs[20] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};

        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        req_data  = {D3, D2, D1, D0};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].rv, vecs[i].ordy);
            check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].rr));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            check($sformatf("v%0d out_sel", i),   32'(out_sel),   32'(vecs[i].sel));
            check($sformatf("v%0d out_data", i),  out_data,       vecs[i].data);
        end

        // Fairness: 8 transfers from ptr=1 with everyone requesting -> two wins each.
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 4'b1111, 1'b1);
            for (int c = 0; c < CH; c++) if (req_ready[c]) cnt[c]++;
            @(posedge clk);
        end
        #1;
        for (int c = 0; c < CH; c++) check($sformatf("fair ch%0d wins", c), 32'(cnt[c]), 32'd2);
        check("fair out_sel", 32'(out_sel), 32'd0);

        // Stall with requesters changing their minds: output and pointer stay frozen.
        drive(1'b0, 4'b0001, 1'b0);
        check("stall0 req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        drive(1'b0, 4'b1010, 1'b0);
        check("stall1 req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        drive(1'b0, 4'b0110, 1'b0);
        check("stall2 req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("stall out_valid", 32'(out_valid), 32'd1);
        check("stall out_sel",   32'(out_sel),   32'd0);
        check("stall out_data",  out_data,       D0);
        drive(1'b0, 4'b0110, 1'b1);
        check("release req_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        check("release out_sel",  32'(out_sel), 32'd1);
        check("release out_data", out_data,     D1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
